// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// Computes diff = a - b - borrow_in one bit per clock, LSB first, through a
// single ripple-borrow cell and a borrow flip-flop. Operands are accepted on
// a valid/ready handshake and the result is offered on a valid/ready
// handshake. One subtraction takes WIDTH run cycles.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    // One extra counter bit so WIDTH itself is representable; the terminal
    // compare is against WIDTH-1, so the counter never wraps.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // a_sr shifts right each run cycle; the vacated MSB collects the
    // difference bits, so after WIDTH shifts it holds the full result and no
    // separate result shift register is needed.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nxt;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] diff_nxt;
    logic             ovf_nxt;

    // Ripple-borrow cell on the current LSBs plus end-of-operation terms
    always_comb begin
        a_i      = a_sr[0];
        b_i      = b_sr[0];
        d_i      = a_i ^ b_i ^ br;
        br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        last_bit = (cnt == CW'(WIDTH - 1));
        diff_nxt = {d_i, a_sr[WIDTH-1:1]};
        // On the MSB cycle a_i/b_i/d_i are the sign bits of a, b and diff.
        ovf_nxt  = (a_i != b_i) && (d_i != a_i);
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst)
                    state_nxt = RUN;
            end
            RUN: begin
                if (last_bit)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= borrow_in;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= diff_nxt;
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    // Result outputs only change on completion so they stay
                    // stable from one result to the next.
                    if (last_bit) begin
                        diff       <= diff_nxt;
                        borrow_out <= br_nxt;
                        overflow   <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, reset
// abort, backpressure, ignored-input and 1000 random operand sets compared
// against an integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] prev_d;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mov);
        int u;
        int s;
        u   = int'(ma) - int'(mb) - int'(mbin);
        s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md  = u[W-1:0];
        mbo = (u < 0);
        mov = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
    endtask

    // One full transaction: accept, run (optionally with noisy inputs),
    // hold the result for 'hold' cycles of backpressure, then drain.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         input int hold, input bit noisy);
        logic [W-1:0] e_d;
        logic         e_bo;
        logic         e_ov;
        int           lat;
        model(oa, ob, obin, e_d, e_bo, e_ov);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        a         = oa;
        b         = ob;
        borrow_in = obin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        if (!noisy) in_valid = 1'b0;
        lat = -1;
        for (int n = 0; n <= W + 4; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            chk("in_ready_run", in_ready, 0);
            chk("diff_hold_run", diff, prev_d);
            if (noisy) begin
                a         = W'($urandom);
                b         = W'($urandom);
                borrow_in = 1'($urandom);
                out_ready = 1'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", lat, W);
        chk("diff", diff, e_d);
        chk("borrow_out", borrow_out, e_bo);
        chk("overflow", overflow, e_ov);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_diff", diff, e_d);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 0);
        chk("drain_in_ready", in_ready, 1);
        chk("drain_diff_kept", diff, e_d);
        prev_d = e_d;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        prev_d    = '0;

        @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow_out", borrow_out, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Directed cases
        do_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h1234, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h0000, 1'b1, 0, 1'b0);
        // Backpressure and ignored input during RUN
        do_op(16'hBEEF, 16'h1234, 1'b0, 5, 1'b0);
        do_op(16'h4321, 16'hA5A5, 1'b1, 1, 1'b1);

        // Reset asserted so that the 7th RUN edge aborts the operation
        @(negedge clk);
        chk("in_ready_pre_abort", in_ready, 1);
        a        = 16'hFFFF;
        b        = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow_out", borrow_out, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_in_ready", in_ready, 1);
        // No late completion after the abort
        repeat (W + 2) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        prev_d = '0;
        do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

        // Random operands
        for (int i = 0; i < 1000; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
